// File: rtl/seqdet_pkg.sv
// -----------------------------------------------------------------------------
// seqdet_pkg
// Shared types and helpers for the parametrised Mealy sequence detector.
//   state_t     : detector FSM states (FILL while history is incomplete,
//                 ARMED once len-1 valid bits are held)
//   PKG_MAX_W   : largest pattern width the mask helper supports
//   LEN_W       : length-field width for the default MAX_W of 8
//   len_mask()  : right-aligned compare mask of 'len' ones
// -----------------------------------------------------------------------------
package seqdet_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam int unsigned PKG_MAX_W = 32;
    localparam int unsigned LEN_W     = $clog2(8 + 1);

    // Built one bit wider than the result so len == PKG_MAX_W yields all-ones
    // instead of wrapping to zero.
    function automatic logic [PKG_MAX_W-1:0] len_mask(input int unsigned len);
        logic [PKG_MAX_W:0] wide;
        wide = ({{PKG_MAX_W{1'b0}}, 1'b1} << len) - {{PKG_MAX_W{1'b0}}, 1'b1};
        return wide[PKG_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// -----------------------------------------------------------------------------
// seqdet_sat_counter
// Saturating up-counter used for the optional match statistics.
//   clk    in   clock, rising edge
//   reset  in   asynchronous, active-high; clears count
//   inc    in   increment request (ignored once count is all-ones)
//   clr    in   synchronous clear, has priority over inc
//   count  out  CNT_W-bit count value
// -----------------------------------------------------------------------------
module seqdet_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_mealy_param.sv
// -----------------------------------------------------------------------------
// seq_detect_mealy_param
// Parametrised Mealy serial-pattern detector with a runtime-loadable pattern
// of 1..MAX_W bits (MAX_W <= 32), overlapping or non-overlapping matching.
// z is asserted in the same cycle as the final pattern bit.
//
// Optional feature macro: SEQDET_MATCH_CNT_EN
//   defined   -> match_count is a saturating count of z pulses
//   undefined -> match_count is tied to zero
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-high
//   x_valid      in   x is sampled this cycle
//   x            in   serial data bit
//   cfg_load     in   1-cycle pulse: capture cfg_* (wins over x_valid)
//   cfg_pattern  in   new pattern, right-aligned, bit [len-1] received first
//   cfg_len      in   new length; 0 or > MAX_W clamps to MAX_W
//   cfg_overlap  in   new overlap mode (1 = overlapping)
//   z            out  combinational match flag
//   armed        out  registered: history holds >= len-1 valid bits
//   match_count  out  saturating match count (macro only, else 0)
// -----------------------------------------------------------------------------
module seq_detect_mealy_param
    import seqdet_pkg::*;
#(
    parameter int unsigned             MAX_W       = 8,
    parameter logic [MAX_W-1:0]        DEF_PATTERN = 'b110,
    parameter int unsigned             DEF_LEN     = 3,
    parameter logic                    DEF_OVERLAP = 1'b1,
    parameter int unsigned             CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       x_valid,
    input  logic                       x,
    input  logic                       cfg_load,
    input  logic [MAX_W-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_W+1)-1:0] cfg_len,
    input  logic                       cfg_overlap,
    output logic                       z,
    output logic                       armed,
    output logic [CNT_W-1:0]           match_count
);

    localparam int unsigned LW = $clog2(MAX_W + 1);

    logic [MAX_W-1:0] pattern_q, pattern_d;
    logic [LW-1:0]    len_q,     len_d;
    logic             overlap_q, overlap_d;
    logic [MAX_W-2:0] hist_q,    hist_d;
    logic [LW-1:0]    fill_q,    fill_d;
    state_t           state_q,   state_d;

    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] window;
    logic [LW-1:0]    len_m1;
    logic [LW-1:0]    fill_inc;
    logic [LW-1:0]    cfg_len_eff;
    logic             hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= LW'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
            hist_q    <= '0;
            fill_q    <= '0;
            state_q   <= (DEF_LEN == 1) ? ARMED : FILL;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            state_q   <= state_d;
        end
    end

    always_comb begin
        mask        = MAX_W'(len_mask(32'(len_q)));
        window      = {hist_q, x};
        len_m1      = len_q - LW'(1);
        fill_inc    = (fill_q == len_m1) ? fill_q : fill_q + LW'(1);
        cfg_len_eff = ((cfg_len == '0) || (cfg_len > LW'(MAX_W))) ? LW'(MAX_W) : cfg_len;

        // A load cycle discards x, so it can never report a match.
        hit = x_valid && !cfg_load && (state_q == ARMED) &&
              ((window & mask) == (pattern_q & mask));
        z   = hit;

        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        state_d   = state_q;

        if (cfg_load) begin
            pattern_d = cfg_pattern;
            len_d     = cfg_len_eff;
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
            state_d   = (cfg_len_eff == LW'(1)) ? ARMED : FILL;
        end else if (x_valid) begin
            if (hit && !overlap_q) begin
                hist_d  = '0;
                fill_d  = '0;
                state_d = (len_q == LW'(1)) ? ARMED : FILL;
            end else begin
                hist_d  = window[MAX_W-2:0];
                fill_d  = fill_inc;
                state_d = (fill_inc == len_m1) ? ARMED : FILL;
            end
        end
    end

    assign armed = (state_q == ARMED);

`ifdef SEQDET_MATCH_CNT_EN
    seqdet_sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hit),
        .clr   (cfg_load),
        .count (match_count)
    );
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_mealy_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_mealy_param
// Directed self-checking bench for seq_detect_mealy_param (MAX_W=8, CNT_W=2).
// Inputs change on the falling edge; z is sampled 1 ns later, registered
// outputs 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_seq_detect_mealy_param;

    localparam int unsigned MAX_W = 8;
    localparam int unsigned CNT_W = 2;

    logic             clk;
    logic             reset;
    logic             x_valid;
    logic             x;
    logic             cfg_load;
    logic [MAX_W-1:0] cfg_pattern;
    logic [3:0]       cfg_len;
    logic             cfg_overlap;
    logic             z;
    logic             armed;
    logic [CNT_W-1:0] match_count;

    int unsigned n_cmp;
    int unsigned n_err;
    int unsigned exp_cnt;

    seq_detect_mealy_param #(
        .MAX_W       (MAX_W),
        .DEF_PATTERN (8'b110),
        .DEF_LEN     (3),
        .DEF_OVERLAP (1'b1),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .x_valid     (x_valid),
        .x           (x),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .z           (z),
        .armed       (armed),
        .match_count (match_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected counter value as the RTL would hold it (0 without the macro).
    function automatic logic [31:0] cnt_exp();
`ifdef SEQDET_MATCH_CNT_EN
        return 32'(exp_cnt);
`else
        return 32'd0;
`endif
    endfunction

    task automatic step(input logic v, input logic b, input logic exp_z, input string tag);
        @(negedge clk);
        cfg_load = 1'b0;
        x_valid  = v;
        x        = b;
        #1;
        chk(tag, {31'd0, z}, {31'd0, exp_z});
        if (exp_z && exp_cnt < 3) exp_cnt++;
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic v, input logic b, input string tag);
        @(negedge clk);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        x_valid     = v;
        x           = b;
        #1;
        chk(tag, {31'd0, z}, 32'd0);
        exp_cnt = 0;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        x_valid  = 1'b0;
    endtask

    task automatic chk_armed(input logic expv, input string tag);
        @(posedge clk);
        #1;
        chk(tag, {31'd0, armed}, {31'd0, expv});
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        exp_cnt     = 0;
        reset       = 1'b1;
        x_valid     = 1'b0;
        x           = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        #12;
        chk("rst_armed", {31'd0, armed}, 32'd0);
        chk("rst_cnt", {30'd0, match_count}, 32'd0);
        chk("rst_z", {31'd0, z}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1: default 110 pattern
        step(1, 1, 0, "d110_b1");
        step(1, 1, 0, "d110_b2");
        chk_armed(1, "d110_armed");
        step(1, 0, 1, "d110_b3");
        step(1, 1, 0, "d1110_b1");
        step(1, 1, 0, "d1110_b2");
        step(1, 1, 0, "d1110_b3");
        step(1, 0, 1, "d1110_b4");
        chk_armed(1, "d1110_armed");
        chk("cnt_sat1", {30'd0, match_count}, cnt_exp());

        // 2: 1010 overlapping then non-overlapping
        load(8'b1010, 4'd4, 1'b1, 1, 1, "ld1010o_z");
        chk("ld1010o_armed", {31'd0, armed}, 32'd0);
        chk("ld1010o_cnt", {30'd0, match_count}, 32'd0);
        step(1, 1, 0, "ov_b1");
        step(1, 0, 0, "ov_b2");
        step(1, 1, 0, "ov_b3");
        step(1, 0, 1, "ov_b4");
        step(1, 1, 0, "ov_b5");
        step(1, 0, 1, "ov_b6");
        load(8'b1010, 4'd4, 1'b0, 0, 0, "ld1010n_z");
        step(1, 1, 0, "nov_b1");
        step(1, 0, 0, "nov_b2");
        step(1, 1, 0, "nov_b3");
        step(1, 0, 1, "nov_b4");
        step(1, 1, 0, "nov_b5");
        step(1, 0, 0, "nov_b6");
        chk_armed(0, "nov_armed");

        // 3: valid gaps, including a gap whose x would complete the pattern
        load(8'b110, 4'd3, 1'b1, 0, 0, "ld110_z");
        step(1, 1, 0, "gap_v1");
        step(0, 1, 0, "gap_g1");
        step(1, 1, 0, "gap_v2");
        step(0, 0, 0, "gap_g2");
        step(1, 0, 1, "gap_v3");

        // 4: full width, clamped length, single-bit pattern
        load(8'hA5, 4'd8, 1'b1, 0, 0, "ldA5_z");
        step(1, 1, 0, "a5_b1");
        step(1, 0, 0, "a5_b2");
        step(1, 1, 0, "a5_b3");
        step(1, 0, 0, "a5_b4");
        step(1, 0, 0, "a5_b5");
        step(1, 1, 0, "a5_b6");
        step(1, 0, 0, "a5_b7");
        chk_armed(1, "a5_armed7");
        step(1, 1, 1, "a5_b8");
        load(8'hA5, 4'd0, 1'b0, 1, 1, "ldclamp_z");
        step(1, 1, 0, "cl_b1");
        step(1, 0, 0, "cl_b2");
        step(1, 1, 0, "cl_b3");
        step(1, 0, 0, "cl_b4");
        step(1, 0, 0, "cl_b5");
        step(1, 1, 0, "cl_b6");
        step(1, 0, 0, "cl_b7");
        step(1, 1, 1, "cl_b8");
        load(8'b1, 4'd1, 1'b1, 0, 0, "ld1_z");
        chk("ld1_armed", {31'd0, armed}, 32'd1);
        step(1, 1, 1, "l1_s1");
        step(1, 0, 0, "l1_s2");
        step(0, 1, 0, "l1_s3");
        step(1, 1, 1, "l1_s4");

        // 5: load on a matching final bit, then async reset mid-pattern
        load(8'b110, 4'd3, 1'b1, 0, 0, "ld110b_z");
        step(1, 1, 0, "lc_b1");
        step(1, 1, 0, "lc_b2");
        load(8'b110, 4'd3, 1'b1, 1, 0, "lc_coinc_z");
        chk("lc_armed", {31'd0, armed}, 32'd0);
        step(1, 1, 0, "lc_b4");
        step(1, 0, 0, "lc_b5");
        step(1, 1, 0, "ar_b1");
        step(1, 1, 0, "ar_b2");
        #1;
        reset = 1'b1;
        exp_cnt = 0;
        #1;
        chk("ar_armed", {31'd0, armed}, 32'd0);
        chk("ar_cnt", {30'd0, match_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1, 0, 0, "ar_b3");
        step(1, 1, 0, "ar_b4");
        step(1, 1, 0, "ar_b5");
        step(1, 0, 1, "ar_b6");

        // 6: counter saturation and clear
        load(8'b1, 4'd1, 1'b1, 0, 0, "cnt_ld_z");
        step(1, 1, 1, "cnt_m1");
        step(1, 1, 1, "cnt_m2");
        step(1, 1, 1, "cnt_m3");
        step(1, 1, 1, "cnt_m4");
        step(1, 1, 1, "cnt_m5");
        @(posedge clk);
        #1;
        chk("cnt_sat", {30'd0, match_count}, cnt_exp());
        load(8'b1, 4'd1, 1'b1, 0, 0, "cnt_clr_z");
        chk("cnt_clr", {30'd0, match_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
